// File: rtl/mem_responder_if.sv
// CPU-to-memory request/response bundle for mem_responder.
// Master drives the request side; slave returns data, ready, error and busy.
interface mem_responder_if;
  logic [31:0] in_address_bus;
  logic        in_mem_write_en;
  logic [31:0] in_mem_write_data;
  logic        in_mem_req;
  logic [31:0] out_mem_read_data;
  logic        out_mem_ready;
  logic        out_mem_error;
  logic        out_mem_busy;

  modport master (
    output in_address_bus, in_mem_write_en, in_mem_write_data, in_mem_req,
    input  out_mem_read_data, out_mem_ready, out_mem_error, out_mem_busy
  );

  modport slave (
    input  in_address_bus, in_mem_write_en, in_mem_write_data, in_mem_req,
    output out_mem_read_data, out_mem_ready, out_mem_error, out_mem_busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with WAIT_STATES wait cycles and fault decode.
// Ready pulses WAIT_STATES+1 cycles after acceptance; requests are only taken in IDLE.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           ram [DEPTH];

  logic [31:0]           acc_addr, acc_wdata, offset;
  logic                  acc_we, fault, do_access, ram_we;
  logic [ADDR_WIDTH-1:0] idx;

  // With zero wait states the access happens on the acceptance edge, so use live inputs.
  always_comb begin
    acc_addr  = (state_q == IDLE) ? bus.in_address_bus    : addr_q;
    acc_we    = (state_q == IDLE) ? bus.in_mem_write_en   : we_q;
    acc_wdata = (state_q == IDLE) ? bus.in_mem_write_data : wdata_q;
    offset    = acc_addr - BASE_ADDR;
    fault     = (offset[1:0] != 2'b00) || (offset[31:ADDR_WIDTH+2] != '0);
    idx       = offset[ADDR_WIDTH+1:2];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_mem_req) begin
          addr_d  = bus.in_address_bus;
          we_d    = bus.in_mem_write_en;
          wdata_d = bus.in_mem_write_data;
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    if (do_access) begin
      if (fault) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end else begin
        err_d = 1'b0;
        if (acc_we) begin
          ram_we = 1'b1;
        end else begin
          rdata_d = ram[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= acc_wdata;
    end
  end

  assign bus.out_mem_read_data = rdata_q;
  assign bus.out_mem_ready     = (state_q == DONE);
  assign bus.out_mem_error     = (state_q == DONE) && err_q;
  assign bus.out_mem_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances cover WAIT_STATES 1/0/3 and a non-zero BASE_ADDR.
module tb_mem_responder;
  logic        clk;
  logic        rst;
  logic        req   [4];
  logic        we    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        rdy   [4];
  logic        err   [4];
  logic        busy  [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          dev;
    logic [31:0] data;
    logic        err;
    int          lat;
  } sb_t;

  sb_t         sb [$];
  logic [31:0] mdl [int];
  logic [31:0] mdl_rd [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder_if ifc ();
    assign ifc.in_mem_req        = req[g];
    assign ifc.in_mem_write_en   = we[g];
    assign ifc.in_address_bus    = addr[g];
    assign ifc.in_mem_write_data = wdata[g];
    assign rdata[g] = ifc.out_mem_read_data;
    assign rdy[g]   = ifc.out_mem_ready;
    assign err[g]   = ifc.out_mem_error;
    assign busy[g]  = ifc.out_mem_busy;

    mem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_STATES(g == 0 ? 1 : (g == 2 ? 3 : 0)),
      .BASE_ADDR  (g == 3 ? 32'h0000_4000 : 32'h0000_0000)
    ) u_dut (
      .clk  (clk),
      .reset(rst),
      .bus  (ifc)
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 2) ? 3 : 0);
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 3) ? 32'h0000_4000 : 32'h0000_0000;
  endfunction

  function automatic bit is_fault(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(d);
    return (a[1:0] != 2'b00) || ((off >> 2) >= 32'd1024);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    sb_t it;
    int  k;
    it.dev = d;
    it.lat = ws_of(d);
    if (is_fault(d, a)) begin
      it.err  = 1'b1;
      it.data = 32'h0;
    end else begin
      it.err = 1'b0;
      k = d * 4096 + int'((a - base_of(d)) >> 2);
      if (w) begin
        mdl[k]  = wd;
        it.data = mdl_rd[d];
      end else begin
        it.data = mdl[k];
      end
    end
    mdl_rd[d] = it.data;
    sb.push_back(it);
  endtask

  task automatic sb_check(input int d, input int n);
    sb_t it;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      it = sb.pop_front();
      chk("sb_dev", 32'(d), 32'(it.dev));
      chk("latency", 32'(n), 32'(it.lat));
      chk("rdata", rdata[d], it.data);
      chk("error", 32'(err[d]), 32'(it.err));
      chk("busy_in_done", 32'(busy[d]), 32'd1);
    end
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_seen", 32'(rdy[d]), 32'd1);
    sb_check(d, n);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(rdy[d]), 32'd0);
    chk("error_low", 32'(err[d]), 32'd0);
    chk("busy_idle", 32'(busy[d]), 32'd0);
  endtask

  // Inputs are scrambled right after acceptance; the DUT must use the latched values.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    push_exp(d, w, a, wd);
    @(negedge clk);
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    @(posedge clk); #1;
    req[d]   = 1'b0;
    we[d]    = ~w;
    addr[d]  = 32'hFFFF_FFF0;
    wdata[d] = 32'hDEAD_BEEF;
    chk("busy_accept", 32'(busy[d]), 32'd1);
    wait_ready(d);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      req[d]    = 1'b0;
      we[d]     = 1'b0;
      addr[d]   = 32'h0;
      wdata[d]  = 32'h0;
      mdl_rd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_ready", 32'(rdy[d]), 32'd0);
      chk("rst_error", 32'(err[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
    end

    // One wait state: write then read back
    access(0, 1'b1, 32'h0000_0010, 32'hCAFE_0001);
    access(0, 1'b0, 32'h0000_0010, 32'h0);

    // Zero wait states: back-to-back reads with req held high
    access(1, 1'b1, 32'h0000_0000, 32'hAAAA_0000);
    access(1, 1'b1, 32'h0000_0004, 32'hBBBB_0004);
    push_exp(1, 1'b0, 32'h0000_0000, 32'h0);
    push_exp(1, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    req[1]  = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 32'h0000_0000;
    @(posedge clk); #1;
    sb_check(1, 0);
    addr[1] = 32'h0000_0004;
    @(posedge clk); #1;
    chk("b2b_busy_gap", 32'(busy[1]), 32'd0);
    chk("b2b_ready_gap", 32'(rdy[1]), 32'd0);
    @(posedge clk); #1;
    sb_check(1, 0);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_busy_end", 32'(busy[1]), 32'd0);
    chk("b2b_ready_end", 32'(rdy[1]), 32'd0);

    // Faults: misaligned, out of range, faulting writes leave RAM alone
    access(0, 1'b0, 32'h0000_0002, 32'h0);
    access(0, 1'b0, 32'h0000_1000, 32'h0);
    access(0, 1'b1, 32'h0000_0012, 32'hDEAD_0BAD);
    access(0, 1'b1, 32'h0000_1010, 32'hDEAD_0BAD);
    access(0, 1'b0, 32'h0000_0010, 32'h0);
    access(0, 1'b1, 32'h0000_0FFC, 32'h0FFC_0FFC);
    access(0, 1'b0, 32'h0000_0FFC, 32'h0);

    // Three wait states: inputs changing during WAIT are ignored
    access(2, 1'b1, 32'h0000_0020, 32'h5555_AAAA);
    access(2, 1'b1, 32'h0000_0024, 32'h1111_2222);
    access(2, 1'b0, 32'h0000_0020, 32'h0);
    access(2, 1'b0, 32'h0000_0024, 32'h0);

    // Reset in WAIT of a write: the write is dropped
    access(2, 1'b1, 32'h0000_0008, 32'h0BAD_F00D);
    access(2, 1'b0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    req[2]   = 1'b1;
    we[2]    = 1'b1;
    addr[2]  = 32'h0000_0008;
    wdata[2] = 32'h1234_5678;
    @(posedge clk); #1;
    req[2] = 1'b0;
    chk("pre_rst_busy", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata", rdata[2], 32'h0);
    chk("mid_rst_ready", 32'(rdy[2]), 32'd0);
    chk("mid_rst_error", 32'(err[2]), 32'd0);
    chk("mid_rst_busy", 32'(busy[2]), 32'd0);
    for (int d = 0; d < 4; d++) mdl_rd[d] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    access(2, 1'b0, 32'h0000_0008, 32'h0);

    // Non-zero base address
    access(3, 1'b1, 32'h0000_4000, 32'h7777_0000);
    access(3, 1'b0, 32'h0000_3FFC, 32'h0);
    access(3, 1'b0, 32'h0000_4000, 32'h0);
    access(3, 1'b0, 32'h0000_5000, 32'h0);
    access(3, 1'b1, 32'h0000_4FFC, 32'h4FFC_0001);
    access(3, 1'b0, 32'h0000_4FFC, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
